// File: rtl/agex_stage.sv
// LC-3b AGEX stage: ALU, shifter and address adder feeding the AGEX->MEM
// pipeline register, with a valid/ready handshake, stall and flush.
module agex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        de_valid,
    output logic        de_ready,
    input  logic [15:0] de_ir,
    input  logic [15:0] de_sr1,
    input  logic [15:0] de_sr2,
    input  logic [15:0] de_npc,
    input  logic        flush,
    input  logic        mem_ready,
    output logic        agex_valid,
    output logic [15:0] agex_ir,
    output logic [15:0] agex_npc,
    output logic [15:0] agex_result,
    output logic [15:0] agex_st_data,
    output logic [2:0]  agex_dr,
    output logic        agex_ld_reg,
    output logic        agex_set_cc,
    output logic [2:0]  agex_cc
);

    typedef enum logic [3:0] {
        OP_ADD = 4'b0001,
        OP_LDB = 4'b0010,
        OP_STB = 4'b0011,
        OP_AND = 4'b0101,
        OP_LDW = 4'b0110,
        OP_STW = 4'b0111,
        OP_XOR = 4'b1001,
        OP_SHF = 4'b1101,
        OP_LEA = 4'b1110
    } opcode_e;

    logic [15:0] imm5_sext;
    logic [15:0] off6_sext;
    logic [15:0] off6_x2;
    logic [15:0] off9_x2;
    logic [15:0] op_b;
    logic [15:0] shf_out;
    logic [15:0] result_c;
    logic        ld_reg_c;
    logic        set_cc_c;
    logic [2:0]  cc_c;
    logic        load;

    assign imm5_sext = {{11{de_ir[4]}}, de_ir[4:0]};
    assign off6_sext = {{10{de_ir[5]}}, de_ir[5:0]};
    assign off6_x2   = {off6_sext[14:0], 1'b0};
    assign off9_x2   = {{6{de_ir[8]}}, de_ir[8:0], 1'b0};
    assign op_b      = de_ir[5] ? imm5_sext : de_sr2;

    Shifter u_shifter (
        .in         (de_sr1),
        .shift_ctrl (de_ir[5:0]),
        .out        (shf_out)
    );

    // Per-opcode result select and register-write / cc-update flags
    always_comb begin
        result_c = '0;
        ld_reg_c = 1'b0;
        set_cc_c = 1'b0;
        case (de_ir[15:12])
            OP_ADD: begin result_c = de_sr1 + op_b;      ld_reg_c = 1'b1; set_cc_c = 1'b1; end
            OP_AND: begin result_c = de_sr1 & op_b;      ld_reg_c = 1'b1; set_cc_c = 1'b1; end
            OP_XOR: begin result_c = de_sr1 ^ op_b;      ld_reg_c = 1'b1; set_cc_c = 1'b1; end
            OP_SHF: begin result_c = shf_out;            ld_reg_c = 1'b1; set_cc_c = 1'b1; end
            OP_LEA: begin result_c = de_npc + off9_x2;   ld_reg_c = 1'b1; end
            OP_LDB: begin result_c = de_sr1 + off6_sext; ld_reg_c = 1'b1; end
            OP_STB: begin result_c = de_sr1 + off6_sext; end
            OP_LDW: begin result_c = de_sr1 + off6_x2;   ld_reg_c = 1'b1; end
            OP_STW: begin result_c = de_sr1 + off6_x2;   end
            default: ;
        endcase
    end

    // N/Z/P from the computed result; exactly one bit set
    always_comb begin
        if (result_c[15])
            cc_c = 3'b100;
        else if (result_c == 16'h0000)
            cc_c = 3'b010;
        else
            cc_c = 3'b001;
    end

    assign de_ready = !rst && (!agex_valid || mem_ready);
    assign load     = de_valid && de_ready && !flush;

    // AGEX->MEM register: reset, then flush, then load, then consume; else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            agex_valid   <= 1'b0;
            agex_ir      <= '0;
            agex_npc     <= '0;
            agex_result  <= '0;
            agex_st_data <= '0;
            agex_dr      <= '0;
            agex_ld_reg  <= 1'b0;
            agex_set_cc  <= 1'b0;
            agex_cc      <= '0;
        end else if (flush) begin
            agex_valid <= 1'b0;
        end else if (load) begin
            agex_valid   <= 1'b1;
            agex_ir      <= de_ir;
            agex_npc     <= de_npc;
            agex_result  <= result_c;
            agex_st_data <= de_sr2;
            agex_dr      <= de_ir[11:9];
            agex_ld_reg  <= ld_reg_c;
            agex_set_cc  <= set_cc_c;
            agex_cc      <= cc_c;
        end else if (agex_valid && mem_ready) begin
            agex_valid <= 1'b0;
        end
    end

endmodule

// LC-3b SHF unit: ctrl[4]=0 left; ctrl[4]=1 right, ctrl[5] selects arithmetic
module Shifter (
    input  logic [15:0] in,
    input  logic [5:0]  shift_ctrl,
    output logic [15:0] out
);

    logic [3:0] amount;

    assign amount = shift_ctrl[3:0];

    // Direction and fill selection
    always_comb begin
        out = in;
        if (!shift_ctrl[4])
            out = in << amount;
        else if (shift_ctrl[5])
            out = $signed(in) >>> amount;
        else
            out = in >> amount;
    end

endmodule

// File: tb/tb_agex_stage.sv
// Directed-vector bench for agex_stage: table of back-to-back instructions
// plus hand-written reset, stall, flush and consume sequences.
module tb_agex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        de_valid;
    logic        de_ready;
    logic [15:0] de_ir;
    logic [15:0] de_sr1;
    logic [15:0] de_sr2;
    logic [15:0] de_npc;
    logic        flush;
    logic        mem_ready;
    logic        agex_valid;
    logic [15:0] agex_ir;
    logic [15:0] agex_npc;
    logic [15:0] agex_result;
    logic [15:0] agex_st_data;
    logic [2:0]  agex_dr;
    logic        agex_ld_reg;
    logic        agex_set_cc;
    logic [2:0]  agex_cc;

    int n_vec = 0;
    int n_err = 0;

    agex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .de_valid     (de_valid),
        .de_ready     (de_ready),
        .de_ir        (de_ir),
        .de_sr1       (de_sr1),
        .de_sr2       (de_sr2),
        .de_npc       (de_npc),
        .flush        (flush),
        .mem_ready    (mem_ready),
        .agex_valid   (agex_valid),
        .agex_ir      (agex_ir),
        .agex_npc     (agex_npc),
        .agex_result  (agex_result),
        .agex_st_data (agex_st_data),
        .agex_dr      (agex_dr),
        .agex_ld_reg  (agex_ld_reg),
        .agex_set_cc  (agex_set_cc),
        .agex_cc      (agex_cc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] sr1;
        logic [15:0] sr2;
        logic [15:0] npc;
        logic [15:0] result;
        logic        ld_reg;
        logic        set_cc;
        logic [2:0]  cc;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ir, input logic [15:0] sr1,
                         input logic [15:0] sr2, input logic [15:0] npc);
        de_ir  = ir;
        de_sr1 = sr1;
        de_sr2 = sr2;
        de_npc = npc;
    endtask

    initial begin
        //           ir        sr1       sr2       npc       result    ld    scc   cc
        vecs[0]  = '{16'h1261, 16'h7FFF, 16'h0000, 16'h0100, 16'h8000, 1'b1, 1'b1, 3'b100}; // ADD imm overflow
        vecs[1]  = '{16'hD0F4, 16'h8010, 16'h0000, 16'h0102, 16'hF801, 1'b1, 1'b1, 3'b100}; // RSHFA 4
        vecs[2]  = '{16'hD0D4, 16'h8010, 16'h0000, 16'h0104, 16'h0801, 1'b1, 1'b1, 3'b001}; // RSHFL 4
        vecs[3]  = '{16'hD001, 16'h8010, 16'h0000, 16'h0106, 16'h0020, 1'b1, 1'b1, 3'b001}; // LSHF 1
        vecs[4]  = '{16'h61BF, 16'h3000, 16'h0000, 16'h0108, 16'h2FFE, 1'b1, 1'b0, 3'b001}; // LDW off -1
        vecs[5]  = '{16'h1042, 16'h0005, 16'hFFFB, 16'h010A, 16'h0000, 1'b1, 1'b1, 3'b010}; // ADD reg -> zero
        vecs[6]  = '{16'h502F, 16'h1234, 16'h0000, 16'h010C, 16'h0004, 1'b1, 1'b1, 3'b001}; // AND imm 15
        vecs[7]  = '{16'h5030, 16'h1234, 16'h0000, 16'h010E, 16'h1230, 1'b1, 1'b1, 3'b001}; // AND imm -16
        vecs[8]  = '{16'h903F, 16'h00FF, 16'h0000, 16'h0110, 16'hFF00, 1'b1, 1'b1, 3'b100}; // NOT via XOR
        vecs[9]  = '{16'h24BF, 16'h1000, 16'h0000, 16'h0112, 16'h0FFF, 1'b1, 1'b0, 3'b001}; // LDB off -1 unscaled
        vecs[10] = '{16'h3020, 16'h0010, 16'hBEEF, 16'h0114, 16'hFFF0, 1'b0, 1'b0, 3'b100}; // STB off -32
        vecs[11] = '{16'h701F, 16'h2000, 16'hCAFE, 16'h0116, 16'h203E, 1'b0, 1'b0, 3'b001}; // STW off +31 scaled
        vecs[12] = '{16'hE1FF, 16'h1111, 16'h0000, 16'h4002, 16'h4000, 1'b1, 1'b0, 3'b001}; // LEA off9 -1
        vecs[13] = '{16'hE0FF, 16'h1111, 16'h0000, 16'h3000, 16'h31FE, 1'b1, 1'b0, 3'b001}; // LEA off9 +255
        vecs[14] = '{16'h0E05, 16'hFFFF, 16'h1234, 16'h0118, 16'h0000, 1'b0, 1'b0, 3'b010}; // BR passthrough
        vecs[15] = '{16'hF025, 16'hFFFF, 16'h0000, 16'h011A, 16'h0000, 1'b0, 1'b0, 3'b010}; // TRAP passthrough
        vecs[16] = '{16'h1042, 16'hFFFF, 16'h0002, 16'h011C, 16'h0001, 1'b1, 1'b1, 3'b001}; // ADD reg wrap

        // Reset held two cycles with an instruction presented
        rst = 1'b1; flush = 1'b0; mem_ready = 1'b1; de_valid = 1'b1;
        drive(16'h1261, 16'h7FFF, 16'h0000, 16'h0100);
        tick();
        tick();
        chk("rst_de_ready", {15'd0, de_ready}, 16'h0000);
        chk("rst_valid", {15'd0, agex_valid}, 16'h0000);
        chk("rst_ir", agex_ir, 16'h0000);
        chk("rst_npc", agex_npc, 16'h0000);
        chk("rst_result", agex_result, 16'h0000);
        chk("rst_st_data", agex_st_data, 16'h0000);
        chk("rst_flags", {9'd0, agex_dr, agex_ld_reg, agex_set_cc, agex_cc}, 16'h0000);

        rst = 1'b0; de_valid = 1'b0;
        tick();
        chk("post_rst_de_ready", {15'd0, de_ready}, 16'h0001);
        chk("post_rst_valid", {15'd0, agex_valid}, 16'h0000);

        // Back-to-back table: every cycle a new instruction, mem_ready high
        de_valid = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].ir, vecs[i].sr1, vecs[i].sr2, vecs[i].npc);
            chk($sformatf("v%0d_de_ready", i), {15'd0, de_ready}, 16'h0001);
            tick();
            chk($sformatf("v%0d_valid", i), {15'd0, agex_valid}, 16'h0001);
            chk($sformatf("v%0d_result", i), agex_result, vecs[i].result);
            chk($sformatf("v%0d_cc", i), {13'd0, agex_cc}, {13'd0, vecs[i].cc});
            chk($sformatf("v%0d_ld_reg", i), {15'd0, agex_ld_reg}, {15'd0, vecs[i].ld_reg});
            chk($sformatf("v%0d_set_cc", i), {15'd0, agex_set_cc}, {15'd0, vecs[i].set_cc});
            chk($sformatf("v%0d_dr", i), {13'd0, agex_dr}, {13'd0, vecs[i].ir[11:9]});
            chk($sformatf("v%0d_ir", i), agex_ir, vecs[i].ir);
            chk($sformatf("v%0d_npc", i), agex_npc, vecs[i].npc);
            chk($sformatf("v%0d_st_data", i), agex_st_data, vecs[i].sr2);
        end

        // Consume with nothing new: valid drops, data holds
        de_valid = 1'b0;
        tick();
        chk("drain_valid", {15'd0, agex_valid}, 16'h0000);
        chk("drain_result_hold", agex_result, 16'h0001);

        // Stall: XOR 0x5A5A ^ 0x0F0F = 0x5555, then hold mem_ready low 3 cycles
        de_valid = 1'b1;
        drive(16'h9442, 16'h5A5A, 16'h0F0F, 16'h0200);
        tick();
        chk("stall_load_result", agex_result, 16'h5555);
        mem_ready = 1'b0;
        drive(16'h1261, 16'h0001, 16'h0000, 16'h0202);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_de_ready", c), {15'd0, de_ready}, 16'h0000);
            tick();
            chk($sformatf("stall%0d_valid", c), {15'd0, agex_valid}, 16'h0001);
            chk($sformatf("stall%0d_result", c), agex_result, 16'h5555);
            chk($sformatf("stall%0d_ir", c), agex_ir, 16'h9442);
            chk($sformatf("stall%0d_npc", c), agex_npc, 16'h0200);
        end
        mem_ready = 1'b1;
        #1;
        chk("unstall_de_ready", {15'd0, de_ready}, 16'h0001);
        tick();
        chk("unstall_valid", {15'd0, agex_valid}, 16'h0001);
        chk("unstall_result", agex_result, 16'h0002);
        chk("unstall_ir", agex_ir, 16'h1261);

        // Flush during stall with an incoming instruction
        mem_ready = 1'b0; flush = 1'b1;
        drive(16'hE1FF, 16'h0000, 16'h0000, 16'h4002);
        tick();
        chk("flush_valid", {15'd0, agex_valid}, 16'h0000);
        flush = 1'b0; de_valid = 1'b0;
        tick();
        chk("flush_no_reappear", {15'd0, agex_valid}, 16'h0000);

        // Flush together with mem_ready: stage ends empty
        de_valid = 1'b1; mem_ready = 1'b1;
        drive(16'h502F, 16'h1234, 16'h0000, 16'h0300);
        tick();
        chk("pre_flush2_valid", {15'd0, agex_valid}, 16'h0001);
        flush = 1'b1;
        tick();
        chk("flush_mem_ready_valid", {15'd0, agex_valid}, 16'h0000);
        flush = 1'b0;

        // Reset while stalled drops the held instruction
        drive(16'h1261, 16'h7FFF, 16'h0000, 16'h0400);
        tick();
        mem_ready = 1'b0; de_valid = 1'b0;
        tick();
        chk("pre_rst_stall_valid", {15'd0, agex_valid}, 16'h0001);
        rst = 1'b1;
        tick();
        chk("rst_stall_valid", {15'd0, agex_valid}, 16'h0000);
        chk("rst_stall_result", agex_result, 16'h0000);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
